// File: rtl/seq_num_manager.sv
// seq_num_manager: per-host FIX sequence-number engine.
// Keeps an outgoing and an incoming counter for every host. Issues the next
// outgoing MsgSeqNum as left-justified ASCII through a bit-serial double-dabble
// converter, and classifies received sequence numbers as in-order, gap or too-low.
module seq_num_manager #(
    parameter int HOST_ADDR_WIDTH = 4,
    parameter int SEQ_BITS        = 32,
    parameter int DIGITS          = 10,
    parameter int INIT_SEQ        = 1,
    parameter int WW              = $clog2(DIGITS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_req_i,
    input  logic [HOST_ADDR_WIDTH-1:0] tx_host_i,
    output logic                       tx_ready_o,
    output logic                       tx_valid_o,
    output logic [8*DIGITS-1:0]        tx_seq_ascii_o,
    output logic [SEQ_BITS-1:0]        tx_seq_bin_o,
    output logic [WW-1:0]              tx_width_o,
    input  logic                       rx_check_i,
    input  logic [HOST_ADDR_WIDTH-1:0] rx_host_i,
    input  logic [SEQ_BITS-1:0]        rx_seq_i,
    output logic                       rx_result_valid_o,
    output logic [1:0]                 rx_status_o,
    output logic [SEQ_BITS-1:0]        rx_expected_o,
    input  logic                       set_i,
    input  logic                       set_sel_i,
    input  logic [HOST_ADDR_WIDTH-1:0] set_host_i,
    input  logic [SEQ_BITS-1:0]        set_value_i
);

    localparam int HOSTS = 1 << HOST_ADDR_WIDTH;
    localparam int BCDW  = 4 * DIGITS;
    localparam int CW    = $clog2(SEQ_BITS);

    localparam logic [SEQ_BITS-1:0] INIT_VAL = SEQ_BITS'(INIT_SEQ);
    localparam logic [SEQ_BITS-1:0] MAX_VAL  = {SEQ_BITS{1'b1}};
    localparam logic [CW-1:0]       LAST_BIT = CW'(SEQ_BITS - 1);

    localparam logic [1:0] RX_IN_ORDER = 2'b00;
    localparam logic [1:0] RX_GAP      = 2'b01;
    localparam logic [1:0] RX_TOO_LOW  = 2'b10;

    // 10^n, wide enough to compare against the binary range at elaboration
    function automatic logic [255:0] pow10_f(input int n);
        logic [255:0] p;
        p = 256'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 256'd10;
        end
        return p;
    endfunction

    localparam logic [255:0] DEC_RANGE = pow10_f(DIGITS);
    localparam logic [255:0] BIN_RANGE = 256'd1 << SEQ_BITS;

    generate
        if (DEC_RANGE < BIN_RANGE) begin : g_digits_too_small
            $error("seq_num_manager: DIGITS cannot represent every SEQ_BITS value");
        end
    endgenerate

    // Successor of a sequence number; the all-ones value wraps to INIT_SEQ so 0 is never issued
    function automatic logic [SEQ_BITS-1:0] next_seq_f(input logic [SEQ_BITS-1:0] v);
        if (v == MAX_VAL) begin
            return INIT_VAL;
        end else begin
            return v + SEQ_BITS'(1'b1);
        end
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } tx_state_e;

    tx_state_e            state_r;
    logic [SEQ_BITS-1:0]  out_ctr_r [HOSTS];
    logic [SEQ_BITS-1:0]  in_ctr_r  [HOSTS];
    logic [SEQ_BITS-1:0]  issued_r;
    logic [SEQ_BITS-1:0]  bin_r;
    logic [BCDW-1:0]      bcd_r;
    logic [CW-1:0]        cnt_r;

    logic                 tx_ready_r;
    logic                 tx_valid_r;
    logic [8*DIGITS-1:0]  tx_ascii_r;
    logic [SEQ_BITS-1:0]  tx_bin_r;
    logic [WW-1:0]        tx_width_r;
    logic                 rx_valid_r;
    logic [1:0]           rx_status_r;
    logic [SEQ_BITS-1:0]  rx_expected_r;

    logic                 tx_accept_s;
    logic [SEQ_BITS-1:0]  tx_cur_s;
    logic [SEQ_BITS-1:0]  rx_cur_s;
    logic [BCDW-1:0]      bcd_adj_s;
    logic [BCDW-1:0]      bcd_step_s;
    logic [SEQ_BITS-1:0]  bin_step_s;
    logic [WW-1:0]        width_s;
    logic [8*DIGITS-1:0]  ascii_s;

    // Request qualification and current counter reads
    always_comb begin
        tx_accept_s = tx_req_i && (state_r == ST_IDLE);
        tx_cur_s    = out_ctr_r[tx_host_i];
        rx_cur_s    = in_ctr_r[rx_host_i];
    end

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift the pair left
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_r[4*d +: 4] >= 4'd5) begin
                bcd_adj_s[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*d +: 4] = bcd_r[4*d +: 4];
            end
        end
        {bcd_step_s, bin_step_s} = {bcd_adj_s, bin_r} << 1;
    end

    // Digit count and left-justified ASCII of the BCD value after the final step
    always_comb begin
        logic [3:0] digit_v;
        int         idx_v;
        width_s = WW'(1'b1);
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_step_s[4*d +: 4] != 4'd0) begin
                width_s = WW'(d + 1);
            end else begin
                width_s = width_s;
            end
        end
        ascii_s = '0;
        digit_v = 4'd0;
        idx_v   = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i < int'(width_s)) begin
                idx_v               = int'(width_s) - 1 - i;
                digit_v             = 4'(bcd_step_s >> (4 * idx_v));
                ascii_s[8*i +: 8]   = 8'h30 + {4'h0, digit_v};
            end else begin
                ascii_s[8*i +: 8]   = 8'h00;
            end
        end
    end

    // TX converter FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tx_ready_r <= 1'b1;
            tx_valid_r <= 1'b0;
            tx_ascii_r <= '0;
            tx_bin_r   <= '0;
            tx_width_r <= '0;
            issued_r   <= '0;
            bin_r      <= '0;
            bcd_r      <= '0;
            cnt_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_valid_r <= 1'b0;
                    if (tx_accept_s) begin
                        issued_r   <= tx_cur_s;
                        bin_r      <= tx_cur_s;
                        bcd_r      <= '0;
                        cnt_r      <= '0;
                        tx_ready_r <= 1'b0;
                        state_r    <= ST_CONV;
                    end else begin
                        tx_ready_r <= 1'b1;
                    end
                end
                ST_CONV: begin
                    bcd_r <= bcd_step_s;
                    bin_r <= bin_step_s;
                    cnt_r <= cnt_r + CW'(1'b1);
                    if (cnt_r == LAST_BIT) begin
                        tx_valid_r <= 1'b1;
                        tx_ascii_r <= ascii_s;
                        tx_width_r <= width_s;
                        tx_bin_r   <= issued_r;
                        state_r    <= ST_DONE;
                    end else begin
                        tx_valid_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    tx_valid_r <= 1'b0;
                    tx_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    tx_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Counter bank: TX/RX increments first, a same-cycle set overrides the written value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < HOSTS; h++) begin
                out_ctr_r[h] <= INIT_VAL;
                in_ctr_r[h]  <= INIT_VAL;
            end
        end else begin
            if (tx_accept_s) begin
                out_ctr_r[tx_host_i] <= next_seq_f(tx_cur_s);
            end
            if (rx_check_i && (rx_seq_i == rx_cur_s)) begin
                in_ctr_r[rx_host_i] <= next_seq_f(rx_cur_s);
            end
            if (set_i) begin
                if (set_sel_i == 1'b0) begin
                    out_ctr_r[set_host_i] <= set_value_i;
                end else begin
                    in_ctr_r[set_host_i] <= set_value_i;
                end
            end
        end
    end

    // RX classification, one cycle after the check request
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_r    <= 1'b0;
            rx_status_r   <= RX_IN_ORDER;
            rx_expected_r <= '0;
        end else begin
            rx_valid_r <= rx_check_i;
            if (rx_check_i) begin
                rx_expected_r <= rx_cur_s;
                if (rx_seq_i == rx_cur_s) begin
                    rx_status_r <= RX_IN_ORDER;
                end else if (rx_seq_i > rx_cur_s) begin
                    rx_status_r <= RX_GAP;
                end else begin
                    rx_status_r <= RX_TOO_LOW;
                end
            end
        end
    end

    assign tx_ready_o        = tx_ready_r;
    assign tx_valid_o        = tx_valid_r;
    assign tx_seq_ascii_o    = tx_ascii_r;
    assign tx_seq_bin_o      = tx_bin_r;
    assign tx_width_o        = tx_width_r;
    assign rx_result_valid_o = rx_valid_r;
    assign rx_status_o       = rx_status_r;
    assign rx_expected_o     = rx_expected_r;

endmodule

// File: tb/tb_seq_num_manager.sv
// Self-checking bench for seq_num_manager: a behavioural model of the counters
// and handshake timing is checked every cycle, plus literal expectations.
module tb_seq_num_manager;

    localparam int SB = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_req_i;
    logic [3:0]  tx_host_i;
    logic        tx_ready_o;
    logic        tx_valid_o;
    logic [79:0] tx_seq_ascii_o;
    logic [31:0] tx_seq_bin_o;
    logic [3:0]  tx_width_o;
    logic        rx_check_i;
    logic [3:0]  rx_host_i;
    logic [31:0] rx_seq_i;
    logic        rx_result_valid_o;
    logic [1:0]  rx_status_o;
    logic [31:0] rx_expected_o;
    logic        set_i;
    logic        set_sel_i;
    logic [3:0]  set_host_i;
    logic [31:0] set_value_i;

    seq_num_manager dut (
        .clk               (clk),
        .rst               (rst),
        .tx_req_i          (tx_req_i),
        .tx_host_i         (tx_host_i),
        .tx_ready_o        (tx_ready_o),
        .tx_valid_o        (tx_valid_o),
        .tx_seq_ascii_o    (tx_seq_ascii_o),
        .tx_seq_bin_o      (tx_seq_bin_o),
        .tx_width_o        (tx_width_o),
        .rx_check_i        (rx_check_i),
        .rx_host_i         (rx_host_i),
        .rx_seq_i          (rx_seq_i),
        .rx_result_valid_o (rx_result_valid_o),
        .rx_status_o       (rx_status_o),
        .rx_expected_o     (rx_expected_o),
        .set_i             (set_i),
        .set_sel_i         (set_sel_i),
        .set_host_i        (set_host_i),
        .set_value_i       (set_value_i)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int edge_n = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [31:0] out_m [16];
    logic [31:0] in_m  [16];
    int          tx_due;
    int          idle_from;
    logic [31:0] tx_pend;
    bit          tx_exp_valid;
    logic [79:0] held_ascii;
    logic [3:0]  held_width;
    logic [31:0] held_bin;
    bit          rx_exp_valid;
    logic [1:0]  rx_exp_status;
    logic [31:0] rx_exp_e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? 32'd1 : v + 32'd1;
    endfunction

    function automatic logic [79:0] ascii_of(input logic [31:0] v);
        string       s;
        logic [79:0] r;
        s = $sformatf("%0d", v);
        r = '0;
        for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [3:0] width_of(input logic [31:0] v);
        string s;
        s = $sformatf("%0d", v);
        return 4'(s.len());
    endfunction

    task automatic model_reset();
        for (int h = 0; h < 16; h++) begin
            out_m[h] = 32'd1;
            in_m[h]  = 32'd1;
        end
        tx_due       = -1;
        idle_from    = edge_n;
        tx_exp_valid = 1'b0;
        rx_exp_valid = 1'b0;
        held_ascii   = '0;
        held_width   = '0;
        held_bin     = '0;
    endtask

    // Model reaction to the inputs sampled at the current rising edge
    task automatic model_step();
        logic [31:0] v_tx;
        logic [31:0] e_rx;
        if (rst) begin
            model_reset();
            chk_en = 1'b1;
        end else begin
            tx_exp_valid = (edge_n == tx_due);
            if (tx_exp_valid) begin
                held_bin   = tx_pend;
                held_ascii = ascii_of(tx_pend);
                held_width = width_of(tx_pend);
                tx_due     = -1;
            end
            v_tx = out_m[tx_host_i];
            e_rx = in_m[rx_host_i];
            if (tx_req_i && (edge_n - 1) >= idle_from) begin
                tx_pend          = v_tx;
                tx_due           = edge_n + SB;
                idle_from        = edge_n + SB + 1;
                out_m[tx_host_i] = nxt(v_tx);
            end
            rx_exp_valid = rx_check_i;
            if (rx_check_i) begin
                rx_exp_e = e_rx;
                if (rx_seq_i == e_rx) begin
                    rx_exp_status   = 2'b00;
                    in_m[rx_host_i] = nxt(e_rx);
                end else if (rx_seq_i > e_rx) begin
                    rx_exp_status = 2'b01;
                end else begin
                    rx_exp_status = 2'b10;
                end
            end
            if (set_i) begin
                if (set_sel_i) in_m[set_host_i] = set_value_i;
                else           out_m[set_host_i] = set_value_i;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        edge_n++;
        model_step();
        @(negedge clk);
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_ready", tx_ready_o, edge_n >= idle_from);
            chk("tx_valid", tx_valid_o, tx_exp_valid);
            chk("tx_bin", tx_seq_bin_o, held_bin);
            chk("tx_ascii", tx_seq_ascii_o, held_ascii);
            chk("tx_width", tx_width_o, held_width);
            chk("rx_valid", rx_result_valid_o, rx_exp_valid);
            if (rx_exp_valid) begin
                chk("rx_status", rx_status_o, rx_exp_status);
                chk("rx_expected", rx_expected_o, rx_exp_e);
            end
        end
    end

    // Issue one TX request, wait for the result and check it against literals
    task automatic tx_req(input int host, input bit spam, input string nm,
                          input logic [79:0] ea, input logic [3:0] ew, input logic [31:0] eb);
        int n;
        tx_req_i  = 1'b1;
        tx_host_i = 4'(host);
        cycle();
        tx_req_i   = spam;
        set_i      = 1'b0;
        rx_check_i = 1'b0;
        n = 0;
        while (!tx_valid_o && n < 40) begin
            cycle();
            n++;
        end
        tx_req_i = 1'b0;
        chk({nm, "_latency"}, n, 32);
        chk({nm, "_ascii"}, tx_seq_ascii_o, ea);
        chk({nm, "_width"}, tx_width_o, ew);
        chk({nm, "_bin"}, tx_seq_bin_o, eb);
        cycle();
    endtask

    task automatic rx_chk(input int host, input logic [31:0] seq,
                          input logic [1:0] es, input logic [31:0] ee);
        rx_check_i = 1'b1;
        rx_host_i  = 4'(host);
        rx_seq_i   = seq;
        cycle();
        set_i = 1'b0;
        chk($sformatf("rx_lit_status_%0d", seq), rx_status_o, es);
        chk($sformatf("rx_lit_expected_%0d", seq), rx_expected_o, ee);
    endtask

    task automatic set_ctr(input bit sel, input int host, input logic [31:0] val);
        set_i       = 1'b1;
        set_sel_i   = sel;
        set_host_i  = 4'(host);
        set_value_i = val;
        cycle();
        set_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tx_req_i = 1'b0; tx_host_i = '0;
        rx_check_i = 1'b0; rx_host_i = '0; rx_seq_i = '0;
        set_i = 1'b0; set_sel_i = 1'b0; set_host_i = '0; set_value_i = '0;
        model_reset();
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        chk("reset_ready", tx_ready_o, 1'b1);
        chk("reset_valid", tx_valid_o, 1'b0);
        chk("reset_bin", tx_seq_bin_o, 32'd0);

        // First issue on host 3, then its successor
        tx_req(3, 1'b0, "h3_first", 80'h31, 4'd1, 32'd1);
        tx_req(3, 1'b0, "h3_second", 80'h32, 4'd1, 32'd2);

        // Maximum value, then wrap to INIT_SEQ
        set_ctr(1'b0, 5, 32'hFFFF_FFFF);
        tx_req(5, 1'b0, "h5_max", 80'h35393237363934393234, 4'd10, 32'hFFFF_FFFF);
        tx_req(5, 1'b0, "h5_wrap", 80'h31, 4'd1, 32'd1);

        // Digit growth 999 -> 1000 with requests while busy ignored
        set_ctr(1'b0, 2, 32'd999);
        tx_req(2, 1'b1, "h2_999", 80'h393939, 4'd3, 32'd999);
        tx_req(2, 1'b1, "h2_1000", 80'h30303031, 4'd4, 32'd1000);
        tx_req(2, 1'b0, "h2_1001", 80'h31303031, 4'd4, 32'd1001);

        // Set colliding with a TX accept on the same counter
        set_i = 1'b1; set_sel_i = 1'b0; set_host_i = 4'd4; set_value_i = 32'd50;
        tx_req(4, 1'b0, "h4_collide", 80'h31, 4'd1, 32'd1);
        tx_req(4, 1'b0, "h4_after_set", 80'h3035, 4'd2, 32'd50);

        // RX classification from reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rx_chk(0, 32'd1, 2'b00, 32'd1);
        rx_chk(0, 32'd2, 2'b00, 32'd2);
        rx_chk(0, 32'd5, 2'b01, 32'd3);
        rx_chk(0, 32'd3, 2'b00, 32'd3);
        rx_chk(0, 32'd4, 2'b00, 32'd4);
        rx_check_i = 1'b0;
        cycle();

        // Set on the incoming counter colliding with an RX check
        set_i = 1'b1; set_sel_i = 1'b1; set_host_i = 4'd1; set_value_i = 32'd10;
        rx_chk(1, 32'd1, 2'b00, 32'd1);
        rx_chk(1, 32'd9, 2'b10, 32'd10);
        rx_chk(1, 32'd10, 2'b00, 32'd10);
        rx_chk(1, 32'd12, 2'b01, 32'd11);
        rx_check_i = 1'b0;
        cycle();

        // TX and RX on host 0 in the same cycle
        rx_check_i = 1'b1; rx_host_i = 4'd0; rx_seq_i = 32'd5;
        tx_req(0, 1'b0, "h0_txrx", 80'h31, 4'd1, 32'd1);

        // Reset in the middle of a conversion
        tx_req_i = 1'b1; tx_host_i = 4'd7;
        cycle();
        tx_req_i = 1'b0;
        repeat (9) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (40) cycle();
        chk("abort_ready", tx_ready_o, 1'b1);
        tx_req(7, 1'b0, "h7_after_abort", 80'h31, 4'd1, 32'd1);

        repeat (3) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seq_num_manager.md
Name: seq_num_manager

Overview:
Per-host FIX sequence-number engine. It holds an outgoing counter and an incoming expected counter for each of 2^HOST_ADDR_WIDTH hosts, and issues the next outgoing MsgSeqNum as left-justified ASCII plus a digit count through a multi-cycle double-dabble converter with a ready/valid handshake. It also classifies received sequence numbers as in-order, gap or too-low. It sits between the session manager, the received-message processor and the message composer.

Parameters:
HOST_ADDR_WIDTH, 4, log2 of host count; HOSTS = 1<<HOST_ADDR_WIDTH
SEQ_BITS, 32, binary counter width
DIGITS, 10, maximum ASCII digits; elaboration error if 10^DIGITS < 2^SEQ_BITS
INIT_SEQ, 1, value loaded into every counter at reset
WW, $clog2(DIGITS+1), width of the digit-count output

Ports:
clk  in  1  clock
rst  in  1  reset
tx_req_i  in  1  request next outgoing seq num
tx_host_i  in  HOST_ADDR_WIDTH  host for tx_req_i
tx_ready_o  out  1  converter idle; tx_req_i accepted only when high
tx_valid_o  out  1  one-cycle pulse; tx_* data valid
tx_seq_ascii_o  out  8*DIGITS  ASCII digits; byte 0 (bits 7:0) is most significant; unused bytes 0x00
tx_seq_bin_o  out  SEQ_BITS  binary value issued
tx_width_o  out  WW  number of significant digits
rx_check_i  in  1  check received seq num
rx_host_i  in  HOST_ADDR_WIDTH  host for rx_check_i
rx_seq_i  in  SEQ_BITS  received MsgSeqNum (binary)
rx_result_valid_o  out  1  one-cycle pulse
rx_status_o  out  2  00 in-order, 01 gap (rx>expected), 10 too-low (rx<expected)
rx_expected_o  out  SEQ_BITS  expected value used for the comparison
set_i  in  1  counter overwrite (logon / SequenceReset)
set_sel_i  in  1  0 = outgoing counter, 1 = incoming counter
set_host_i  in  HOST_ADDR_WIDTH  host to overwrite
set_value_i  in  SEQ_BITS  new counter value

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All 2*HOSTS counters = INIT_SEQ.
  - FSM = IDLE; tx_ready_o = 1 in the cycle after rst deasserts.
  - tx_valid_o, rx_result_valid_o = 0.
  - tx_seq_ascii_o, tx_seq_bin_o, tx_width_o, rx_status_o, rx_expected_o = 0.
- TX FSM states: IDLE, CONV, DONE. tx_ready_o = (state == IDLE).
  - IDLE: on tx_req_i at cycle T, latch value v = out_ctr[tx_host_i]. Write out_ctr <= v+1; if v = 2^SEQ_BITS-1, write INIT_SEQ instead (0 is never issued). Go to CONV.
  - CONV: shift-add-3 double-dabble, one bit per cycle, cycles T+1..T+SEQ_BITS. Go to DONE.
  - DONE (cycle T+SEQ_BITS+1):
    - tx_valid_o = 1.
    - tx_width_o = index of most significant nonzero BCD digit + 1, minimum 1 (v = 0 gives "0", width 1).
    - Digits are left-justified as ASCII 0x30+d.
    - Go to IDLE; ready again at T+SEQ_BITS+2.
  - tx_req_i while ready is low is ignored (no counter change).
  - tx_* data outputs hold until the next DONE.
- RX check (single stage): rx_check_i at T gives result at T+1 with rx_expected_o = e = in_ctr[rx_host_i].
  - rx_seq_i == e: status 00, in_ctr <= e+1 (same wrap rule as TX).
  - rx_seq_i > e: status 01, counter unchanged.
  - rx_seq_i < e: status 10, counter unchanged.
  - Back-to-back checks every cycle are supported; a same-host check in the next cycle sees the updated counter.
- Set: takes effect at T+1.
- Same-cycle collision on the same host and same counter: set wins the written value.
  - A TX accept still issues the pre-set value.
  - An RX check still compares against the pre-set expected value.
  - The increment is discarded.
- TX and RX on the same host in the same cycle touch different counters and proceed independently.
- rst mid-CONV: abort, FSM to IDLE, no tx_valid_o pulse, counters reinitialised.

Test Plan:
- Reset, then tx_req_i with host 3 → tx_valid_o at T+33; ascii byte0 = 0x31, bytes 1..9 = 0x00; width 1; bin 1; next request on host 3 issues 2.
- set_i with sel 0, host 5, value 4294967295; then tx_req_i → ascii "4294967295", width 10; following request issues 1 (wrap to INIT_SEQ).
- set sel 0, host 2, value 999; two requests → "999"/width 3, then "1000"/width 4; tx_req_i pulses while busy are ignored and the counter stays at 1001.
- Reset, then rx on host 0 with seq 1, 2, 5, 3 on consecutive cycles → status 00, 00, 01, 00; rx_expected_o = 1, 2, 3, 3; final expected = 4.
- set sel 1, host 1, value 10 in the same cycle as an rx check on host 1 with seq 1 → status 00 against expected 1; counter = 10; next check with seq 9 → status 10.
- Assert rst at T+10 of a conversion → no tx_valid_o pulse; tx_ready_o high after reset; next request issues INIT_SEQ.
